// File: rtl/pcpi_muldiv.sv
// PCPI multiply/divide co-processor: MUL/MULH/MULHSU/MULHU by iterative shift-add,
// DIV/DIVU/REM/REMU by restoring shift-subtract, one handshake per instruction.
module pcpi_muldiv #(
  parameter int MUL_STEPS  = 1,
  parameter bit ENABLE_DIV = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready
);

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_DONE} state_t;
  typedef enum logic [2:0] {
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } op_t;

  localparam logic [6:0] MUL_ITER  = 7'(32 / MUL_STEPS);
  localparam logic [6:0] MULH_ITER = 7'(64 / MUL_STEPS);
  localparam logic [6:0] DIV_ITER  = 7'd32;

  state_t      state, state_nxt;
  op_t         op;
  logic [6:0]  cnt;
  logic        ready_q;
  logic [31:0] rd_q;

  logic [63:0] mul_a, mul_b, mul_acc, mul_acc_nxt;
  logic [31:0] div_q, div_r, div_b, div_q_nxt, div_r_nxt;
  logic [32:0] div_trial, div_diff;
  logic        neg_q, neg_r;

  logic        start;
  logic        op_is_div, rs1_signed, rs2_signed, div_signed;
  logic [31:0] rs1_mag, rs2_mag, result;
  logic [6:0]  iter;
  logic        unused_insn;

  assign unused_insn = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

  // The ready cycle is excluded so a core still holding pcpi_valid does not re-issue.
  assign start = pcpi_valid && !ready_q
              && pcpi_insn[6:0] == 7'b0110011
              && pcpi_insn[31:25] == 7'b0000001
              && (ENABLE_DIV || !pcpi_insn[14]);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  // NOTE: every comb output gets a default before the case so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_DECODE;
      S_DECODE: state_nxt = pcpi_valid ? S_EXEC : S_IDLE;
      S_EXEC: begin
        if (!pcpi_valid)    state_nxt = S_IDLE;
        else if (cnt == '0) state_nxt = S_DONE;
      end
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    pcpi_wait = (state != S_IDLE);
  end

  assign pcpi_ready = ready_q;
  assign pcpi_wr    = ready_q;
  assign pcpi_rd    = rd_q;

  // ---------------- operand decode ----------------
  always_comb begin
    op_is_div  = op[2];
    rs1_signed = (op == OP_MULH) || (op == OP_MULHSU);
    rs2_signed = (op == OP_MULH);
    div_signed = (op == OP_DIV) || (op == OP_REM);
    rs1_mag    = (div_signed && pcpi_rs1[31]) ? -pcpi_rs1 : pcpi_rs1;
    rs2_mag    = (div_signed && pcpi_rs2[31]) ? -pcpi_rs2 : pcpi_rs2;
    if (op_is_div)        iter = DIV_ITER;
    else if (op == OP_MUL) iter = MUL_ITER;
    else                   iter = MULH_ITER;
  end

  // Sign-extended 64x64 product truncated to 64 bits equals the exact signed/unsigned product.
  // NOTE: blocking assignments here are deliberate; each step accumulates on the previous one.
  always_comb begin
    mul_acc_nxt = mul_acc;
    for (int j = 0; j < MUL_STEPS; j++) begin
      if (mul_b[j]) mul_acc_nxt = mul_acc_nxt + (mul_a << j);
    end
  end

  // Restoring step: the partial remainder stays below the divisor, so 32 bits suffice.
  always_comb begin
    div_trial = {div_r, div_q[31]};
    div_diff  = div_trial - {1'b0, div_b};
    if (!div_diff[32]) begin
      div_r_nxt = div_diff[31:0];
      div_q_nxt = {div_q[30:0], 1'b1};
    end else begin
      div_r_nxt = div_trial[31:0];
      div_q_nxt = {div_q[30:0], 1'b0};
    end
  end

  always_comb begin
    if (op_is_div) begin
      if (op[1]) result = neg_r ? -div_r : div_r;
      else       result = neg_q ? -div_q : div_q;
    end else begin
      result = (op == OP_MUL) ? mul_acc[31:0] : mul_acc[63:32];
    end
  end

  // ---------------- datapath ----------------
  // NOTE: datapath registers carry no reset; the FSM only consumes them after DECODE loads them.
  always_ff @(posedge clk) begin
    case (state)
      S_IDLE: if (start) op <= op_t'(pcpi_insn[14:12]);
      S_DECODE: begin
        mul_a   <= {{32{rs1_signed & pcpi_rs1[31]}}, pcpi_rs1};
        mul_b   <= {{32{rs2_signed & pcpi_rs2[31]}}, pcpi_rs2};
        mul_acc <= '0;
        div_q   <= rs1_mag;
        div_r   <= '0;
        div_b   <= rs2_mag;
        // A zero divisor must yield all-ones quotient regardless of dividend sign.
        neg_q   <= div_signed && (pcpi_rs1[31] ^ pcpi_rs2[31]) && (pcpi_rs2 != '0);
        neg_r   <= div_signed && pcpi_rs1[31];
        cnt     <= iter - 7'd1;
      end
      S_EXEC: begin
        mul_acc <= mul_acc_nxt;
        mul_a   <= mul_a << MUL_STEPS;
        mul_b   <= mul_b >> MUL_STEPS;
        div_q   <= div_q_nxt;
        div_r   <= div_r_nxt;
        cnt     <= cnt - 7'd1;
      end
      default: ;
    endcase
  end

  // ---------------- result / handshake ----------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ready_q <= 1'b0;
      rd_q    <= '0;
    end else begin
      ready_q <= (state == S_DONE);
      if (state == S_DONE) rd_q <= result;
    end
  end

endmodule

// File: tb/tb_pcpi_muldiv.sv
// Directed bench for pcpi_muldiv: three instances (default, MUL_STEPS=4, ENABLE_DIV=0)
// sharing one PCPI request bus; each task watches the instance it targets.
module tb_pcpi_muldiv;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        pcpi_valid = 1'b0;
  logic [31:0] pcpi_insn = '0;
  logic [31:0] pcpi_rs1 = '0;
  logic [31:0] pcpi_rs2 = '0;

  logic [2:0]  wait_v, ready_v, wr_v;
  logic [31:0] rd_v [3];

  int errors = 0;
  int checks = 0;

  localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

  always #5 clk = ~clk;

  pcpi_muldiv u_dut (
    .clk(clk), .resetn(resetn), .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
    .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2), .pcpi_wr(wr_v[0]), .pcpi_rd(rd_v[0]),
    .pcpi_wait(wait_v[0]), .pcpi_ready(ready_v[0])
  );

  pcpi_muldiv #(.MUL_STEPS(4)) u_dut4 (
    .clk(clk), .resetn(resetn), .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
    .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2), .pcpi_wr(wr_v[1]), .pcpi_rd(rd_v[1]),
    .pcpi_wait(wait_v[1]), .pcpi_ready(ready_v[1])
  );

  pcpi_muldiv #(.ENABLE_DIV(1'b0)) u_nodiv (
    .clk(clk), .resetn(resetn), .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
    .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2), .pcpi_wr(wr_v[2]), .pcpi_rd(rd_v[2]),
    .pcpi_wait(wait_v[2]), .pcpi_ready(ready_v[2])
  );

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  // Issues one instruction starting `gap` idle cycles after entry; entry/exit at posedge+1.
  task automatic run_op(input int idx, input int gap, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input string name);
    int n;
    bit seen;
    int wait_bad;
    logic [31:0] got;
    logic        got_wr;
    pcpi_valid = 1'b0;
    repeat (gap) @(posedge clk);
    if (gap > 0) #1;
    pcpi_valid = 1'b1;
    pcpi_insn  = mk(7'b0000001, f3);
    pcpi_rs1   = a;
    pcpi_rs2   = b;
    seen = 1'b0;
    wait_bad = 0;
    got = '0;
    got_wr = 1'b0;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (ready_v[idx] === 1'b1) begin
        seen = 1'b1;
        got = rd_v[idx];
        got_wr = wr_v[idx];
        if (wait_v[idx] !== 1'b0) wait_bad++;
        break;
      end
      if (wait_v[idx] !== (n >= 1)) wait_bad++;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s timeout: no pcpi_ready within 200 cycles, expected at T0+%0d", name, lat);
    end else begin
      if (n != lat) begin
        errors++;
        $display("FAIL %s latency: got T0+%0d expected T0+%0d", name, n, lat);
      end
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s result: got %08h expected %08h", name, got, exp);
      end
      checks++;
      if (got_wr !== 1'b1) begin
        errors++;
        $display("FAIL %s pcpi_wr: got %b expected 1 with ready", name, got_wr);
      end
      checks++;
      if (wait_bad != 0) begin
        errors++;
        $display("FAIL %s wait profile: %0d bad cycles expected 0", name, wait_bad);
      end
    end
    // pcpi_valid stays high through the ready cycle, then drops like a real core.
    @(posedge clk); #1;
    pcpi_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (wait_v[idx] !== 1'b0 || ready_v[idx] !== 1'b0) begin
      errors++;
      $display("FAIL %s after-ready: wait=%b ready=%b expected 0 0", name, wait_v[idx], ready_v[idx]);
    end
    checks++;
    if (rd_v[idx] !== exp) begin
      errors++;
      $display("FAIL %s rd hold: got %08h expected %08h", name, rd_v[idx], exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    pcpi_valid = 1'b1;
    pcpi_insn = mk(7'b0000001, F_MUL);
    pcpi_rs1 = 32'd3;
    pcpi_rs2 = 32'd5;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    pcpi_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({wait_v, ready_v, wr_v} !== 9'd0) begin
      errors++;
      $display("FAIL reset handshake: wait=%b ready=%b wr=%b expected all 0", wait_v, ready_v, wr_v);
    end
    checks++;
    if (rd_v[0] !== 32'd0 || rd_v[1] !== 32'd0 || rd_v[2] !== 32'd0) begin
      errors++;
      $display("FAIL reset rd: got %08h %08h %08h expected 0", rd_v[0], rd_v[1], rd_v[2]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    run_op(0, 4, F_MUL,   32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 35, "mul_neg");
    run_op(0, 4, F_MULH,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 67, "mulh_neg");
    run_op(0, 4, F_MULHU, 32'h80000000, 32'd2,        32'h00000001, 67, "mulhu_carry");
  endtask

  task automatic test_mul_steps4();
    run_op(1, 4, F_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 19, "s4_mulh");
    run_op(1, 4, F_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 19, "s4_mulhu");
    run_op(1, 4, F_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 19, "s4_mulhsu");
    run_op(1, 4, F_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 11, "s4_mul");
  endtask

  task automatic test_div();
    run_op(0, 4, F_DIVU, 32'd100,      32'd2 + 32'd5, 32'd14,       35, "divu");
    run_op(0, 4, F_REMU, 32'd100,      32'd7,         32'd2,        35, "remu");
    run_op(0, 4, F_DIV,  32'hFFFFFFF9, 32'd2,         32'hFFFFFFFD, 35, "div_neg");
    run_op(0, 4, F_REM,  32'hFFFFFFF9, 32'd2,         32'hFFFFFFFF, 35, "rem_neg");
    run_op(0, 4, F_DIV,  32'd7,        32'd0,         32'hFFFFFFFF, 35, "div_by0");
    run_op(0, 4, F_REM,  32'd7,        32'd0,         32'd7,        35, "rem_by0");
    run_op(0, 4, F_DIV,  32'hFFFFFFF9, 32'd0,         32'hFFFFFFFF, 35, "div_neg_by0");
    run_op(0, 4, F_REM,  32'hFFFFFFF9, 32'd0,         32'hFFFFFFF9, 35, "rem_neg_by0");
    run_op(0, 4, F_DIVU, 32'h12345678, 32'd0,         32'hFFFFFFFF, 35, "divu_by0");
    run_op(0, 4, F_REMU, 32'h12345678, 32'd0,         32'h12345678, 35, "remu_by0");
    run_op(0, 4, F_DIV,  32'h80000000, 32'hFFFFFFFF,  32'h80000000, 35, "div_ovf");
    run_op(0, 4, F_REM,  32'h80000000, 32'hFFFFFFFF,  32'd0,        35, "rem_ovf");
  endtask

  task automatic test_unrecognised();
    int bad;
    pcpi_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    pcpi_insn = mk(7'b0000000, 3'b000);
    pcpi_rs1 = 32'd1;
    pcpi_rs2 = 32'd2;
    pcpi_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if ({wait_v, ready_v, wr_v} !== 9'd0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL add_ignored: %0d active cycles expected 0", bad);
    end
    @(posedge clk); #1;
    pcpi_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    pcpi_insn = mk(7'b0000001, F_DIV);
    pcpi_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if ({wait_v[2], ready_v[2], wr_v[2]} !== 3'd0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL nodiv_div_ignored: %0d active cycles expected 0", bad);
    end
    @(posedge clk); #1;
    pcpi_valid = 1'b0;
  endtask

  task automatic test_abort();
    int bad;
    pcpi_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    pcpi_insn = mk(7'b0000001, F_MULH);
    pcpi_rs1 = 32'h11111111;
    pcpi_rs2 = 32'h22222222;
    pcpi_valid = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    pcpi_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (wait_v[0] !== 1'b1) begin
      errors++;
      $display("FAIL abort wait_at_drop: got %b expected 1", wait_v[0]);
    end
    @(negedge clk);
    checks++;
    if (wait_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL abort wait_after: got %b expected 0", wait_v[0]);
    end
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (ready_v[0] !== 1'b0 || wr_v[0] !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL abort no_ready: %0d ready cycles expected 0", bad);
    end
    @(posedge clk); #1;
    run_op(0, 4, F_MUL, 32'd3, 32'd5, 32'd15, 35, "mul_after_abort");
  endtask

  task automatic test_reset_mid();
    int bad;
    pcpi_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    pcpi_insn = mk(7'b0000001, F_MULH);
    pcpi_rs1 = 32'h11111111;
    pcpi_rs2 = 32'h22222222;
    pcpi_valid = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    resetn = 1'b0;
    @(negedge clk);
    checks++;
    if (wait_v[0] !== 1'b1) begin
      errors++;
      $display("FAIL midreset wait_before: got %b expected 1", wait_v[0]);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    pcpi_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (wait_v[0] !== 1'b0 || ready_v[0] !== 1'b0 || rd_v[0] !== 32'd0) begin
      errors++;
      $display("FAIL midreset outputs: wait=%b ready=%b rd=%08h expected 0 0 00000000",
               wait_v[0], ready_v[0], rd_v[0]);
    end
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (ready_v[0] !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL midreset no_ready: %0d ready cycles expected 0", bad);
    end
    @(posedge clk); #1;
    run_op(0, 4, F_MUL, 32'd3, 32'd5, 32'd15, 35, "mul_after_reset");
  endtask

  task automatic test_back_to_back();
    run_op(0, 4, F_DIVU, 32'd100,      32'd7,  32'd14,       35, "b2b_divu");
    run_op(0, 0, F_REMU, 32'd100,      32'd7,  32'd2,        35, "b2b_remu");
    run_op(0, 0, F_MUL,  32'h12345678, 32'h10, 32'h23456780, 35, "b2b_mul");
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mul_steps4();
    test_div();
    test_unrecognised();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
